adc_chunked: RTL and testbench

Parametrised multi-cycle adder/subtractor with carry-in, carry-out and signed-overflow flags. Processes the operands CHUNK bits per clock, least-significant chunk first, and ripples the carry between cycles through a register. It is the ALU-side arithmetic unit for wide or multi-cycle datapaths where a full-width single-cycle carry chain is too slow. A start/busy/done handshake sequences each operation.

---
 rtl/adc_chunked.sv | 101 ++++++++++
 tb/tb_adc_chunked.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_chunked.sv
// adc_chunked: multi-cycle adder/subtractor that processes CHUNK bits per clock,
// least-significant chunk first, rippling the carry between cycles through a register.
// WIDTH must be an integer multiple of CHUNK.
module adc_chunked #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             overflow
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [WIDTH-1:0] res_nx;
   logic             c;
   logic [CW-1:0]    cnt;
   logic [CHUNK:0]   sum;
   logic             accept;
   logic             last;
   logic             msb_cin;

   // Chunk adder, result shifter and FSM next-state; the carry into the MSB is
   // recovered from the top chunk's bits so overflow needs no extra state
   always_comb begin
      state_nx = state;
      accept   = (state == IDLE) && start;
      last     = (state == RUN) && (cnt == LAST_CNT);
      sum      = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]} + {{CHUNK{1'b0}}, c};
      res_nx   = (res_sh >> CHUNK) | (WIDTH'(sum[CHUNK-1:0]) << (WIDTH - CHUNK));
      msb_cin  = a_sh[CHUNK-1] ^ b_sh[CHUNK-1] ^ sum[CHUNK-1];
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Operand capture, per-chunk shifting, and result/flag update on the final chunk
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sh     <= '0;
         b_sh     <= '0;
         res_sh   <= '0;
         c        <= 1'b0;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         s        <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            a_sh <= a;
            b_sh <= sub ? ~b : b;
            c    <= cin ^ sub;
            cnt  <= '0;
            busy <= 1'b1;
         end else if (state == RUN) begin
            a_sh   <= a_sh >> CHUNK;
            b_sh   <= b_sh >> CHUNK;
            res_sh <= res_nx;
            c      <= sum[CHUNK];
            cnt    <= cnt + CW'(1);
            if (last) begin
               s        <= res_nx;
               cout     <= sum[CHUNK];
               overflow <= msb_cin ^ sum[CHUNK];
               done     <= 1'b1;
               busy     <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_adc_chunked.sv
// tb_adc_chunked: scoreboard bench for adc_chunked, five instances with CHUNK = 1, 4, 8, 16, 32
module tb_adc_chunked;

   typedef struct packed {
      logic        ov;
      logic        co;
      logic [31:0] s;
   } res_t;

   logic        clk;
   logic        rst_n;
   logic        st     [5];
   logic [31:0] a_in;
   logic [31:0] b_in;
   logic        cin_in;
   logic        sub_in;
   logic        busy_o [5];
   logic        done_o [5];
   logic [31:0] s_o    [5];
   logic        cout_o [5];
   logic        ov_o   [5];

   res_t sbq[$];
   int   errors = 0;
   int   checks = 0;

   for (genvar g = 0; g < 5; g++) begin : g_dut
      adc_chunked #(
         .WIDTH(32),
         .CHUNK(g == 0 ? 1 : g == 1 ? 4 : g == 2 ? 8 : g == 3 ? 16 : 32)
      ) u_dut (
         .clk(clk), .rst_n(rst_n), .start(st[g]), .a(a_in), .b(b_in),
         .cin(cin_in), .sub(sub_in), .busy(busy_o[g]), .done(done_o[g]),
         .s(s_o[g]), .cout(cout_o[g]), .overflow(ov_o[g])
      );
   end

   // Free-running clock
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Full-width reference: overflow derived from the 31-bit low sum's carry
   function automatic res_t ref_calc(input logic [31:0] av, input logic [31:0] bv,
                                     input logic ci, input logic sb);
      logic [31:0] bp;
      logic        c0;
      logic [32:0] full;
      logic [31:0] low;
      res_t        r;
      bp   = sb ? ~bv : bv;
      c0   = sb ? ~ci : ci;
      full = {1'b0, av} + {1'b0, bp} + {32'd0, c0};
      low  = {1'b0, av[30:0]} + {1'b0, bp[30:0]} + {31'd0, c0};
      r.s  = full[31:0];
      r.co = full[32];
      r.ov = low[31] ^ full[32];
      return r;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic applyStimulus(input int idx, input logic [31:0] av, input logic [31:0] bv,
                                input logic ci, input logic sb);
      a_in    = av;
      b_in    = bv;
      cin_in  = ci;
      sub_in  = sb;
      st[idx] = 1'b1;
   endtask

   // One operation on one instance: latency, result, flags, single-cycle done, hold
   task automatic run_op(input int idx, input int n, input logic [31:0] av, input logic [31:0] bv,
                         input logic ci, input logic sb, input string name);
      res_t e;
      int   cyc;
      bit   seen;
      applyStimulus(idx, av, bv, ci, sb);
      sbq.push_back(ref_calc(av, bv, ci, sb));
      tick();
      st[idx] = 1'b0;
      checks++;
      if (busy_o[idx] !== 1'b1) begin
         errors++;
         $display("[TB] FAIL %s_busy: got %b want 1", name, busy_o[idx]);
      end
      seen = 0;
      cyc  = 0;
      while (!seen && cyc < n + 8) begin
         tick();
         cyc++;
         if (done_o[idx] === 1'b1) seen = 1;
      end
      e = sbq.pop_front();
      checks++;
      if (!seen || cyc != n) begin
         errors++;
         $display("[TB] FAIL %s_latency: got %0d (seen=%0b) want %0d", name, cyc, seen, n);
      end
      checks++;
      if (s_o[idx] !== e.s) begin
         errors++;
         $display("[TB] FAIL %s_s: got %h want %h", name, s_o[idx], e.s);
      end
      checks++;
      if (cout_o[idx] !== e.co || ov_o[idx] !== e.ov) begin
         errors++;
         $display("[TB] FAIL %s_flags: got cout=%b ov=%b want cout=%b ov=%b",
                  name, cout_o[idx], ov_o[idx], e.co, e.ov);
      end
      checks++;
      if (busy_o[idx] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL %s_idle: got busy=%b want 0", name, busy_o[idx]);
      end
      tick();
      checks++;
      if (done_o[idx] !== 1'b0 || s_o[idx] !== e.s) begin
         errors++;
         $display("[TB] FAIL %s_hold: got done=%b s=%h want done=0 s=%h", name, done_o[idx], s_o[idx], e.s);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({busy_o[i], done_o[i], cout_o[i], ov_o[i], s_o[i]} !== 36'h0) begin
            errors++;
            $display("[TB] FAIL reset_%0d: got busy=%b done=%b cout=%b ov=%b s=%h want all 0",
                     i, busy_o[i], done_o[i], cout_o[i], ov_o[i], s_o[i]);
         end
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_add();
      run_op(2, 4, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "add_ovf");
      run_op(2, 4, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, "add_ripple");
   endtask

   task automatic test_sub();
      run_op(2, 4, 32'd5, 32'd7, 1'b0, 1'b1, "sub_neg");
      run_op(2, 4, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, "sub_ovf");
   endtask

   // A second start while busy must be ignored
   task automatic test_ignore_start();
      res_t e;
      int   ndone;
      ndone = 0;
      applyStimulus(2, 32'd1, 32'd2, 1'b0, 1'b0);
      sbq.push_back(ref_calc(32'd1, 32'd2, 1'b0, 1'b0));
      tick();
      checks++;
      if (busy_o[2] !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ign_busy0: got %b want 1", busy_o[2]);
      end
      a_in  = 32'd100;
      b_in  = 32'd100;
      st[2] = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         tick();
         st[2] = 1'b0;
         if (k < 4) begin
            checks++;
            if (busy_o[2] !== 1'b1) begin
               errors++;
               $display("[TB] FAIL ign_busy%0d: got %b want 1", k, busy_o[2]);
            end
         end
         if (done_o[2] === 1'b1) begin
            ndone++;
            if (sbq.size() > 0) begin
               e = sbq.pop_front();
               checks++;
               if (s_o[2] !== e.s) begin
                  errors++;
                  $display("[TB] FAIL ign_s: got %h want %h", s_o[2], e.s);
               end
            end
         end
      end
      checks++;
      if (ndone != 1) begin
         errors++;
         $display("[TB] FAIL ign_done_count: got %0d want 1", ndone);
      end
   endtask

   // Reset two cycles into an operation discards it; a fresh request then works
   task automatic test_reset_midop();
      int ndone;
      ndone = 0;
      applyStimulus(2, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
      tick();
      st[2] = 1'b0;
      tick();
      checks++;
      if (s_o[2] !== 32'd3) begin
         errors++;
         $display("[TB] FAIL midop_hold: got %h want 00000003", s_o[2]);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if ({busy_o[2], done_o[2], cout_o[2], ov_o[2], s_o[2]} !== 36'h0) begin
         errors++;
         $display("[TB] FAIL midop_reset: got busy=%b done=%b cout=%b ov=%b s=%h want all 0",
                  busy_o[2], done_o[2], cout_o[2], ov_o[2], s_o[2]);
      end
      for (int k = 0; k < 6; k++) begin
         tick();
         if (done_o[2] === 1'b1) ndone++;
      end
      checks++;
      if (ndone != 0 || busy_o[2] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midop_nodone: got dones=%0d busy=%b want 0 0", ndone, busy_o[2]);
      end
      run_op(2, 4, 32'd10, 32'd20, 1'b0, 1'b0, "after_reset");
   endtask

   // CHUNK=WIDTH instance with start held high: one result every two cycles
   task automatic test_back_to_back();
      res_t e;
      int   i;
      int   ndone;
      int   last;
      i     = 1;
      ndone = 0;
      last  = -1;
      applyStimulus(4, 32'd1, 32'd1, 1'b0, 1'b0);
      sbq.push_back(ref_calc(32'd1, 32'd1, 1'b0, 1'b0));
      for (int cyc = 0; cyc < 20 && ndone < 4; cyc++) begin
         tick();
         if (busy_o[4] === 1'b1) begin
            if (i < 4) begin
               i++;
               a_in = i;
               b_in = i;
               sbq.push_back(ref_calc(a_in, b_in, 1'b0, 1'b0));
            end else begin
               st[4] = 1'b0;
            end
         end
         if (done_o[4] === 1'b1 && sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (s_o[4] !== e.s) begin
               errors++;
               $display("[TB] FAIL b2b_s%0d: got %h want %h", ndone, s_o[4], e.s);
            end
            if (last >= 0) begin
               checks++;
               if (cyc - last != 2) begin
                  errors++;
                  $display("[TB] FAIL b2b_gap%0d: got %0d want 2", ndone, cyc - last);
               end
            end
            last = cyc;
            ndone++;
         end
      end
      st[4] = 1'b0;
      checks++;
      if (ndone != 4) begin
         errors++;
         $display("[TB] FAIL b2b_count: got %0d want 4", ndone);
      end
      sbq.delete();
      tick();
      tick();
   endtask

   // Random add/sub vectors run in parallel on the CHUNK=1,4,8,16 instances
   task automatic test_random();
      res_t        e;
      res_t        got_r [4];
      bit          got   [4];
      bit          all;
      int          cyc;
      logic [31:0] av;
      logic [31:0] bv;
      logic        ci;
      logic        sb;
      for (int v = 0; v < 1000; v++) begin
         av = $urandom;
         bv = $urandom;
         ci = 1'($urandom_range(0, 1));
         sb = 1'($urandom_range(0, 1));
         for (int i = 0; i < 4; i++) applyStimulus(i, av, bv, ci, sb);
         sbq.push_back(ref_calc(av, bv, ci, sb));
         tick();
         for (int i = 0; i < 4; i++) begin
            st[i]  = 1'b0;
            got[i] = 0;
            got_r[i] = '0;
         end
         all = 0;
         cyc = 0;
         while (!all && cyc < 40) begin
            tick();
            cyc++;
            all = 1;
            for (int i = 0; i < 4; i++) begin
               if (!got[i] && done_o[i] === 1'b1) begin
                  got_r[i] = {ov_o[i], cout_o[i], s_o[i]};
                  got[i]   = 1;
               end
               if (!got[i]) all = 0;
            end
         end
         e = sbq.pop_front();
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (!got[i] || got_r[i] !== e) begin
               errors++;
               $display("[TB] FAIL rand_v%0d_i%0d: a=%h b=%h cin=%b sub=%b got done=%b ov=%b cout=%b s=%h want ov=%b cout=%b s=%h",
                        v, i, av, bv, ci, sb, got[i], got_r[i].ov, got_r[i].co, got_r[i].s, e.ov, e.co, e.s);
            end
         end
      end
   endtask

   // Test sequence
   initial begin
      clk    = 1'b0;
      rst_n  = 1'b0;
      a_in   = '0;
      b_in   = '0;
      cin_in = 1'b0;
      sub_in = 1'b0;
      for (int i = 0; i < 5; i++) st[i] = 1'b0;
      test_reset();
      test_add();
      test_sub();
      test_ignore_start();
      test_reset_midop();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
